// File: rtl/note_mixer_tx_pkg.sv
// note_pkg: shared constants and types for the note mixer / DAC transmitter.
//   NUM_NOTES, SAMPLE_W : default note count and sample width
//   SAT_MAX             : largest positive 16-bit two's-complement sample
//   mix_state_t         : mixer FSM encoding
//   IDX_*               : note index constants, 0 = C1 ... 35 = B3
package note_pkg;

  localparam int          NUM_NOTES = 36;
  localparam int          SAMPLE_W  = 16;
  localparam logic [15:0] SAT_MAX   = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } mix_state_t;

  localparam int IDX_C1  = 0,  IDX_CS1 = 1,  IDX_D1  = 2,  IDX_DS1 = 3;
  localparam int IDX_E1  = 4,  IDX_F1  = 5,  IDX_FS1 = 6,  IDX_G1  = 7;
  localparam int IDX_GS1 = 8,  IDX_A1  = 9,  IDX_AS1 = 10, IDX_B1  = 11;
  localparam int IDX_C2  = 12, IDX_CS2 = 13, IDX_D2  = 14, IDX_DS2 = 15;
  localparam int IDX_E2  = 16, IDX_F2  = 17, IDX_FS2 = 18, IDX_G2  = 19;
  localparam int IDX_GS2 = 20, IDX_A2  = 21, IDX_AS2 = 22, IDX_B2  = 23;
  localparam int IDX_C3  = 24, IDX_CS3 = 25, IDX_D3  = 26, IDX_DS3 = 27;
  localparam int IDX_E3  = 28, IDX_F3  = 29, IDX_FS3 = 30, IDX_G3  = 31;
  localparam int IDX_GS3 = 32, IDX_A3  = 33, IDX_AS3 = 34, IDX_B3  = 35;

endpackage

// File: rtl/note_mixer_tx_if.sv
// note_mixer_tx_if: bundle between the note generator / key scanner, the
// mixer and the codec pins.
//   notes, keys                    : note amplitudes and key bits (into mixer)
//   bclk, lrclk, sdata             : left-justified serial audio (out of mixer)
//   sample, sample_valid, active_cnt : last mix result and its status
// modport master = mixer side, modport slave = producer/consumer side.
interface note_mixer_tx_if #(
  parameter int NUM_NOTES = note_pkg::NUM_NOTES,
  parameter int SAMPLE_W  = note_pkg::SAMPLE_W
);
  import note_pkg::*;

  logic [NUM_NOTES*SAMPLE_W-1:0] notes;
  logic [NUM_NOTES-1:0]          keys;
  logic                          bclk;
  logic                          lrclk;
  logic                          sdata;
  logic [SAMPLE_W-1:0]           sample;
  logic                          sample_valid;
  logic [5:0]                    active_cnt;

  modport master (
    input  notes, keys,
    output bclk, lrclk, sdata, sample, sample_valid, active_cnt
  );

  modport slave (
    output notes, keys,
    input  bclk, lrclk, sdata, sample, sample_valid, active_cnt
  );

endinterface

// File: rtl/note_mixer_tx_audio_serializer.sv
// audio_serializer: left-justified stereo frame generator.
//   clk, rst    : system clock, synchronous active-low reset
//   word        : mono sample, latched for both channels at frame start
//   bclk        : bit clock, clk/(2*BCLK_HALF)
//   lrclk       : 0 = left word, 1 = right word
//   sdata       : serial data, MSB first, changes on bclk falling edges
//   frame_start : one-cycle strobe on the falling edge that wraps bit 31->0
module audio_serializer
  import note_pkg::*;
#(
  parameter int BCLK_HALF = 8,
  parameter int WORD_W    = SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start
);

  localparam int FRAME_BITS = 2 * WORD_W;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int HC_W       = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [HC_W-1:0]       r_hcnt;
  logic                  r_bclk;
  logic                  r_lrclk;
  logic                  r_sdata;
  logic [BC_W-1:0]       r_bitcnt;
  logic [FRAME_BITS-1:0] r_shift;

  logic                  w_tc;
  logic                  w_fall;
  logic                  w_wrap;
  logic [BC_W-1:0]       w_bit_nxt;

  assign w_tc      = (r_hcnt == HC_W'(BCLK_HALF - 1));
  assign w_fall    = w_tc & r_bclk;
  assign w_wrap    = w_fall & (r_bitcnt == BC_W'(FRAME_BITS - 1));
  assign w_bit_nxt = w_wrap ? '0 : r_bitcnt + 1'b1;

  // r_shift[MSB] is always the bit currently on sdata; the word MSB goes out
  // in the same slot as the lrclk transition (left-justified, no delay bit).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hcnt   <= '0;
      r_bclk   <= 1'b0;
      r_lrclk  <= 1'b0;
      r_sdata  <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      if (w_tc) begin
        r_hcnt <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_fall) begin
        r_bitcnt <= w_bit_nxt;
        r_lrclk  <= (w_bit_nxt >= BC_W'(WORD_W));
        if (w_wrap) begin
          r_shift <= {word, word};
          r_sdata <= word[WORD_W-1];
        end else begin
          r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
          r_sdata <= r_shift[FRAME_BITS-2];
        end
      end
    end
  end

  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign sdata       = r_sdata;
  assign frame_start = w_wrap;

endmodule

// File: rtl/note_mixer_tx.sv
// note_mixer_tx: gates each note by its key, sums the gated notes one per
// clock, saturates to a positive 16-bit sample and sends it to the DAC as a
// left-justified stereo frame (same sample on both channels).
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : note_mixer_tx_if.master -- notes/keys in; bclk/lrclk/sdata,
//         sample/sample_valid/active_cnt out
// A mix starts on each frame_start; its result is heard in the next frame.
module note_mixer_tx #(
  parameter int NUM_NOTES = note_pkg::NUM_NOTES,
  parameter int SAMPLE_W  = note_pkg::SAMPLE_W,
  parameter int ACC_W     = 22,
  parameter int BCLK_HALF = 8
) (
  input  logic             clk,
  input  logic             rst,
  note_mixer_tx_if.master  bus
);
  import note_pkg::*;

  localparam int IDX_W = $clog2(NUM_NOTES);

  generate
    if (BCLK_HALF < 1 || 64 * BCLK_HALF <= NUM_NOTES + 1) begin : g_bad_cfg
      $error("note_mixer_tx: BCLK_HALF must be >= 1 and a frame must outlast one mix");
    end
  endgenerate

  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [ACC_W-1:0] a);
    if (a > ACC_W'(SAT_MAX)) return SAMPLE_W'(SAT_MAX);
    return a[SAMPLE_W-1:0];
  endfunction

  function automatic logic [5:0] popcount(input logic [NUM_NOTES-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_NOTES; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  mix_state_t           r_state;
  mix_state_t           w_state_nxt;
  logic                 w_load;
  logic                 w_add;
  logic                 w_sat;
  logic                 w_frame_start;

  logic [NUM_NOTES-1:0] r_key_q;
  logic [ACC_W-1:0]     r_acc;
  logic [IDX_W-1:0]     r_idx;
  logic [SAMPLE_W-1:0]  r_sample;
  logic [5:0]           r_active_cnt;
  logic [SAMPLE_W-1:0]  w_note [NUM_NOTES];

  always_comb begin
    for (int i = 0; i < NUM_NOTES; i++) w_note[i] = bus.notes[i*SAMPLE_W +: SAMPLE_W];
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_sat       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_frame_start) begin
          w_load      = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        w_add = 1'b1;
        if (r_idx == IDX_W'(NUM_NOTES - 1)) w_state_nxt = SAT;
      end
      SAT: begin
        w_sat       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Keys are frozen at frame start; notes are read live each ACCUM cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_key_q      <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_sample     <= '0;
      r_active_cnt <= '0;
    end else begin
      if (w_load) begin
        r_key_q <= bus.keys;
        r_acc   <= '0;
        r_idx   <= '0;
      end
      if (w_add) begin
        r_acc <= r_acc + (r_key_q[r_idx] ? ACC_W'(w_note[r_idx]) : '0);
        r_idx <= r_idx + 1'b1;
      end
      if (w_sat) begin
        r_sample     <= sat_sample(r_acc);
        r_active_cnt <= popcount(r_key_q);
      end
    end
  end

  audio_serializer #(
    .BCLK_HALF (BCLK_HALF),
    .WORD_W    (SAMPLE_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .word        (r_sample),
    .bclk        (bus.bclk),
    .lrclk       (bus.lrclk),
    .sdata       (bus.sdata),
    .frame_start (w_frame_start)
  );

  // sample_valid is high during SAT, the cycle whose closing edge loads the
  // new sample/active_cnt; the new values are visible the cycle after.
  assign bus.sample       = r_sample;
  assign bus.active_cnt   = r_active_cnt;
  assign bus.sample_valid = w_sat;

endmodule

// File: tb/tb_note_mixer_tx.sv
module tb_note_mixer_tx;

  localparam int NN = 36;
  localparam int SW = 16;

  typedef struct packed {
    logic [15:0] s;
    logic [5:0]  c;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  exp_t sb_q[$];

  note_mixer_tx_if #(.NUM_NOTES(NN), .SAMPLE_W(SW)) bus ();

  note_mixer_tx #(
    .NUM_NOTES (NN),
    .SAMPLE_W  (SW),
    .ACC_W     (22),
    .BCLK_HALF (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sample(input logic [NN*SW-1:0] n, input logic [NN-1:0] k);
    int sum;
    sum = 0;
    for (int i = 0; i < NN; i++) if (k[i]) sum += int'(n[i*SW +: SW]);
    if (sum > 32767) return 16'h7FFF;
    return sum[15:0];
  endfunction

  task automatic set_all_notes(input logic [15:0] v);
    for (int i = 0; i < NN; i++) bus.notes[i*SW +: SW] = v;
  endtask

  task automatic set_note(input int i, input logic [15:0] v);
    bus.notes[i*SW +: SW] = v;
  endtask

  // Scoreboard consumer: on each valid pulse pop the expectation and compare
  // against the values loaded by that pulse's closing edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.sample_valid === 1'b1) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        @(posedge clk);
        #1;
        chk("sample", 64'(bus.sample), 64'(e.s));
        chk("active_cnt", 64'(bus.active_cnt), 64'(e.c));
        chk("valid_one_cycle", 64'(bus.sample_valid), 64'(0));
      end
    end
  end

  // Wait for frame_start, push the expected mix, then follow the frame:
  // check mix latency and capture sdata/lrclk at each bclk rising edge.
  task automatic frame(input string tag, input logic [15:0] exp_word,
                       input int chg_k, input logic [NN-1:0] chg_val);
    int          k;
    int          vk;
    int          nb;
    logic        prev;
    logic [31:0] dbits;
    logic [31:0] lbits;
    exp_t        e;
    k = 0;
    while (dut.w_frame_start !== 1'b1 && k < 600) begin
      tick();
      k++;
    end
    chk({tag, "_fs_seen"}, 64'(dut.w_frame_start), 64'(1));
    e.s = model_sample(bus.notes, bus.keys);
    e.c = 6'($countones(bus.keys));
    sb_q.push_back(e);
    vk    = -1;
    nb    = 0;
    prev  = bus.bclk;
    dbits = '0;
    lbits = '0;
    for (k = 1; k <= 560 && !(nb == 32 && k > 40); k++) begin
      tick();
      if (k == chg_k) bus.keys = chg_val;
      if (bus.sample_valid === 1'b1 && vk < 0) vk = k;
      if (prev === 1'b0 && bus.bclk === 1'b1 && nb < 32) begin
        dbits = {dbits[30:0], bus.sdata};
        lbits = {lbits[30:0], bus.lrclk};
        nb++;
      end
      prev = bus.bclk;
    end
    chk({tag, "_latency"}, 64'(vk), 64'(37));
    chk({tag, "_sdata"}, 64'(dbits), 64'({exp_word, exp_word}));
    chk({tag, "_lrclk"}, 64'(lbits), 64'(32'h0000_FFFF));
  endtask

  initial begin
    int   n;
    logic sd_or;
    n_total = 0;
    n_bad   = 0;

    // Reset held with all keys pressed
    rst       = 1'b0;
    bus.keys  = '1;
    set_all_notes(16'h3FFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_outputs", 64'({bus.bclk, bus.lrclk, bus.sdata, bus.sample_valid,
                              bus.active_cnt, bus.sample}), 64'(0));
    end

    // Single note 9 for the first mix after release
    set_all_notes(16'h0000);
    set_note(9, 16'h1FFF);
    bus.keys = '0;
    bus.keys[9] = 1'b1;
    rst = 1'b1;
    n = 0;
    while (bus.bclk !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("first_bclk_rise", 64'(n), 64'(8));
    while (dut.w_frame_start !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("first_frame_start", 64'(n), 64'(511));
    frame("single", 16'h0000, 0, '0);

    // Notes 0 and 35 summed
    set_all_notes(16'h0000);
    set_note(0, 16'h1FFF);
    set_note(35, 16'h1FFF);
    bus.keys = '0;
    bus.keys[0]  = 1'b1;
    bus.keys[35] = 1'b1;
    frame("two", 16'h1FFF, 0, '0);

    // Saturation with every key pressed
    set_all_notes(16'h3FFF);
    bus.keys = '1;
    frame("satur", 16'h3FFE, 0, '0);

    // Key snapshot: keys change at ACCUM clk 5
    set_all_notes(16'h0000);
    set_note(0, 16'h0100);
    set_note(1, 16'h0200);
    bus.keys = 36'h1;
    frame("snap", 16'h7FFF, 5, 36'h2);

    // New keys take effect on the next snapshot
    frame("keys2", 16'h0100, 0, '0);

    // No keys -> silence
    bus.keys = '0;
    frame("keys0", 16'h0200, 0, '0);

    // Reset asserted at ACCUM clk 10
    set_all_notes(16'h3FFF);
    bus.keys = '1;
    n = 0;
    while (dut.w_frame_start !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("mid_fs_seen", 64'(dut.w_frame_start), 64'(1));
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_outputs", 64'({bus.bclk, bus.lrclk, bus.sdata, bus.sample_valid,
                                bus.active_cnt, bus.sample}), 64'(0));
    rst   = 1'b1;
    n     = 0;
    sd_or = 1'b0;
    while (dut.w_frame_start !== 1'b1 && n < 600) begin
      tick();
      n++;
      sd_or = sd_or | bus.sdata;
      if (n == 255) chk("post_rst_lrclk_left", 64'(bus.lrclk), 64'(0));
      if (n == 256) chk("post_rst_lrclk_right", 64'(bus.lrclk), 64'(1));
    end
    chk("post_rst_frame_start", 64'(n), 64'(511));
    chk("post_rst_sdata_zero", 64'(sd_or), 64'(0));
    chk("post_rst_sample", 64'(bus.sample), 64'(0));
    frame("post_rst", 16'h0000, 0, '0);

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
